// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-transmitter handshake bundle for uart_tx_arbiter.
// The arbiter side uses modport master, the surrounding system uses slave.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic               tx_valid;
   logic [7:0]         tx_data;
   logic               tx_ready;
   logic [N_REQ-1:0]   grant;
   logic               timeout_err;

   modport master (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data, grant, timeout_err
   );

   modport slave (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data, grant, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter merging N_REQ byte streams onto one UART
// transmitter, with an optional per-frame header byte and an idle timeout.
module uart_tx_arbiter #(
   parameter int          N_REQ     = 4,
   parameter bit          HEADER_EN = 1'b1,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic            clock,
   input  logic            reset_n,
   uart_tx_arbiter_if.master bus
);
   localparam int unsigned NR = N_REQ;
   localparam int          W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int          CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HEADER = 2'd1;
   localparam logic [1:0] S_DATA   = 2'd2;

   logic [1:0]    r_state;
   logic [W-1:0]  r_winner;
   logic [W-1:0]  r_last;
   logic [CW-1:0] r_cnt;
   logic          r_timeout_err;

   logic          w_xfer;
   logic          w_sel_valid;
   logic          w_sel_last;
   logic [7:0]    w_sel_data;
   logic          w_any;
   logic [W-1:0]  w_pick;
   logic [W-1:0]  w_cand;

   assign w_sel_valid = bus.req_valid[r_winner];
   assign w_sel_last  = bus.req_last[r_winner];
   assign w_sel_data  = bus.req_data[{r_winner, 3'b000} +: 8];
   assign w_xfer      = bus.tx_valid & bus.tx_ready;

   // Round-robin search starting just after the previous owner.
   always_comb begin
      w_any  = 1'b0;
      w_pick = r_last;
      w_cand = r_last;
      for (int unsigned k = 1; k <= NR; k++) begin
         w_cand = W'((32'(r_last) + k) % NR);
         if (!w_any && bus.req_valid[w_cand]) begin
            w_any  = 1'b1;
            w_pick = w_cand;
         end
      end
   end

   always_comb begin
      bus.tx_valid    = 1'b0;
      bus.tx_data     = '0;
      bus.req_ready   = '0;
      bus.grant       = '0;
      bus.timeout_err = r_timeout_err;
      if (r_state != S_IDLE) begin
         bus.grant = N_REQ'(1) << r_winner;
      end
      case (r_state)
         S_HEADER: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'hA0 | 8'(r_winner);
         end
         S_DATA: begin
            bus.tx_valid  = w_sel_valid;
            bus.tx_data   = w_sel_valid ? w_sel_data : 8'h00;
            bus.req_ready = N_REQ'(bus.tx_ready) << r_winner;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_winner      <= '0;
         r_last        <= W'(N_REQ - 1);
         r_cnt         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_winner <= w_pick;
                  r_cnt    <= '0;
                  r_state  <= HEADER_EN ? S_HEADER : S_DATA;
               end
            end
            S_HEADER: begin
               if (w_xfer) begin
                  r_cnt   <= '0;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_cnt <= '0;
                  if (w_sel_last) begin
                     r_last  <= r_winner;
                     r_state <= S_IDLE;
                  end
               end else if (!w_sel_valid) begin
                  // Revoke on the edge where the idle count would reach TIMEOUT.
                  if (r_cnt == CW'(TIMEOUT - 1)) begin
                     r_cnt         <= '0;
                     r_last        <= r_winner;
                     r_timeout_err <= 1'b1;
                     r_state       <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small per-requester byte source.
module tb_uart_tx_arbiter;
   logic clock;
   logic reset_n;

   uart_tx_arbiter_if #(.N_REQ(4)) bus ();

   uart_tx_arbiter #(
      .N_REQ     (4),
      .HEADER_EN (1'b1),
      .TIMEOUT   (8)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [8:0]  mem [4][16];
   int unsigned hd [4];
   int unsigned tl [4];
   logic [3:0]  en;

   logic [63:0] txlog;
   int unsigned txn;
   int unsigned ticks;
   int unsigned xfer_first;
   int unsigned xfer_last;
   int unsigned g2_cnt;
   int unsigned terr_cnt;

   logic        s_txv;
   logic [7:0]  s_txd;
   logic [3:0]  s_rdy;
   logic [3:0]  s_val;
   logic [3:0]  s_grant;
   logic        s_terr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < 4; i++) begin
         if (en[i] && hd[i] != tl[i]) begin
            v[i]         = 1'b1;
            l[i]         = mem[i][hd[i]][8];
            d[8*i +: 8]  = mem[i][hd[i]][7:0];
         end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
   endtask

   task automatic push(input int i, input logic [7:0] b, input logic last);
      mem[i][tl[i]] = {last, b};
      tl[i]++;
   endtask

   task automatic clear_log();
      txlog = '0; txn = 0; xfer_first = 0; xfer_last = 0; g2_cnt = 0; terr_cnt = 0;
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic tick();
      #3;
      s_txv   = bus.tx_valid;
      s_txd   = bus.tx_data;
      s_rdy   = bus.req_ready;
      s_val   = bus.req_valid;
      s_grant = bus.grant;
      s_terr  = bus.timeout_err;
      ticks++;
      if (s_txv && bus.tx_ready) begin
         txlog = {txlog[55:0], s_txd};
         if (txn == 0) xfer_first = ticks;
         xfer_last = ticks;
         txn++;
      end
      if (s_grant == 4'b0010) g2_cnt++;
      if (s_terr) terr_cnt++;
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (s_rdy[i] && s_val[i]) hd[i]++;
      end
      drive();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      en = '0;
      bus.tx_ready = 1'b1;
      drive();
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      clear_log();
   endtask

   initial begin
      int unsigned n;
      logic        found;
      ticks = 0;
      clear_log();

      // Reset state
      do_reset();
      check("rst_grant", 64'(bus.grant), 64'h0);
      check("rst_tx_valid", 64'(bus.tx_valid), 64'h0);
      check("rst_tx_data", 64'(bus.tx_data), 64'h0);
      check("rst_req_ready", 64'(bus.req_ready), 64'h0);
      check("rst_timeout_err", 64'(bus.timeout_err), 64'h0);

      // Single frame on requester 1
      push(1, 8'h41, 1'b0);
      push(1, 8'h42, 1'b1);
      en = 4'b1111;
      drive();
      repeat (6) tick();
      check("single_log", txlog, 64'hA1_41_42);
      check("single_count", 64'(txn), 64'd3);
      check("single_grant_cycles", 64'(g2_cnt), 64'd3);
      check("single_grant_end", 64'(s_grant), 64'h0);

      // Contention: four one-byte frames, round-robin from requester 0
      do_reset();
      for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i), 1'b1);
      en = 4'b1111;
      drive();
      repeat (14) tick();
      check("contend_log", txlog, 64'hA0_10_A1_11_A2_12_A3_13);
      check("contend_count", 64'(txn), 64'd8);
      check("contend_span", 64'(xfer_last - xfer_first), 64'd10);

      // Frame lock: requester 0 appears while requester 2 owns the bus
      do_reset();
      push(2, 8'h21, 1'b0);
      push(2, 8'h22, 1'b0);
      push(2, 8'h23, 1'b1);
      push(0, 8'h01, 1'b1);
      en = 4'b0100;
      drive();
      repeat (2) tick();
      en = 4'b0101;
      drive();
      repeat (8) tick();
      check("lock_log", txlog, 64'hA2_21_22_23_A0_01);
      check("lock_count", 64'(txn), 64'd6);

      // Backpressure for 5 cycles in DATA
      do_reset();
      push(1, 8'h51, 1'b0);
      push(1, 8'h52, 1'b0);
      push(1, 8'h53, 1'b1);
      en = 4'b0010;
      drive();
      repeat (3) tick();
      bus.tx_ready = 1'b0;
      repeat (5) begin
         tick();
         check("bp_tx_valid", 64'(s_txv), 64'h1);
         check("bp_tx_data", 64'(s_txd), 64'h52);
         check("bp_req_ready", 64'(s_rdy), 64'h0);
      end
      bus.tx_ready = 1'b1;
      repeat (4) tick();
      check("bp_log", txlog, 64'hA1_51_52_53);
      check("bp_count", 64'(txn), 64'd4);
      check("bp_no_timeout", 64'(terr_cnt), 64'd0);

      // Timeout: requester 3 sends one non-last byte, then goes quiet
      do_reset();
      push(3, 8'h31, 1'b0);
      en = 4'b1111;
      drive();
      repeat (3) tick();
      check("to_pre_log", txlog, 64'hA3_31);
      n = 0;
      found = 1'b0;
      while (!found && n < 20) begin
         tick();
         n++;
         if (s_terr) found = 1'b1;
      end
      check("to_edges_after_xfer", 64'(n - 1), 64'd8);
      check("to_grant_cleared", 64'(s_grant), 64'h0);
      tick();
      check("to_pulse_width", 64'(s_terr), 64'h0);
      clear_log();
      push(0, 8'h02, 1'b1);
      push(2, 8'h12, 1'b1);
      drive();
      repeat (8) tick();
      check("to_next_log", txlog, 64'hA0_02_A2_12);
      check("to_next_count", 64'(txn), 64'd4);

      // Asynchronous reset between edges, mid-frame
      do_reset();
      push(1, 8'h61, 1'b0);
      push(1, 8'h62, 1'b0);
      push(1, 8'h63, 1'b1);
      en = 4'b1111;
      drive();
      repeat (3) tick();
      check("ar_pre_log", txlog, 64'hA1_61);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_tx_valid", 64'(bus.tx_valid), 64'h0);
      check("ar_grant", 64'(bus.grant), 64'h0);
      check("ar_req_ready", 64'(bus.req_ready), 64'h0);
      check("ar_tx_data", 64'(bus.tx_data), 64'h0);
      clear_log();
      push(0, 8'h07, 1'b1);
      drive();
      #2;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      repeat (10) tick();
      check("ar_post_log", txlog, 64'hA0_07_A1_62_63);
      check("ar_post_count", 64'(txn), 64'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL provide parameter N_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 The block SHALL provide parameter HEADER_EN, default 1; when 1, a header byte precedes each frame.
REQ-003 The block SHALL provide parameter TIMEOUT, default 1024, idle cycles allowed inside a frame before the grant is revoked.
REQ-004 The block SHALL provide port clock  input  1  single system clock, all logic rising-edge.
REQ-005 The block SHALL provide port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL provide port req_valid  input  N_REQ  per-requester byte valid.
REQ-007 The block SHALL provide port req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 The block SHALL provide port req_last  input  N_REQ  per-requester end-of-frame marker, qualified by req_valid.
REQ-009 The block SHALL provide port req_ready  output  N_REQ  per-requester byte accepted this cycle.
REQ-010 The block SHALL provide port tx_valid  output  1  byte offered to the UART transmitter.
REQ-011 The block SHALL provide port tx_data  output  8  byte to transmit.
REQ-012 The block SHALL provide port tx_ready  input  1  UART transmitter accepts tx_data this cycle.
REQ-013 The block SHALL provide port grant  output  N_REQ  one-hot current owner; all-zero when idle.
REQ-014 The block SHALL provide port timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 A transfer SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; no other edge moves data.
REQ-016 States SHALL be IDLE, HEADER, DATA.
REQ-017 IDLE: grant=0, tx_valid=0; on any req_valid=1, the block SHALL pick the winner and move to HEADER (HEADER_EN=1) or DATA (HEADER_EN=0) next cycle with grant one-hot.
REQ-018 Arbitration SHALL be round-robin: search starts at index (last_winner+1) mod N_REQ, ascending with wrap; last_winner resets to N_REQ-1, so requester 0 wins first.
REQ-019 HEADER: tx_valid=1, tx_data=8'hA0 | winner index; on transfer, move to DATA; req_ready stays 0.
REQ-020 DATA: tx_valid=req_valid[w], tx_data=req_data of w, req_ready[w]=tx_ready; all other req_ready bits 0; these paths SHALL be combinational, with no added cycles.
REQ-021 DATA: on a transfer with req_last[w]=1, the block SHALL return to IDLE, clear grant and update last_winner=w; re-arbitration happens in IDLE the next cycle.
REQ-022 Grant SHALL be held for the whole frame; req_valid from other requesters SHALL be ignored until the frame ends.
REQ-023 Timeout counter: SHALL clear on entry to HEADER/DATA and on every transfer, and increment each DATA cycle with req_valid[w]=0.
REQ-024 When the counter reaches TIMEOUT, the block SHALL go to IDLE, clear grant, set last_winner=w and pulse timeout_err for exactly one cycle.
REQ-025 A timeout SHALL take no effect in a cycle where a transfer occurs.
REQ-026 HEADER SHALL NOT time out; a stalled tx_ready holds HEADER indefinitely.
REQ-027 req_last on a non-granted requester SHALL have no effect.
REQ-028 tx_data SHALL be 8'h00 whenever tx_valid=0.

Reset
REQ-029 With reset_n=0, the block SHALL immediately force state=IDLE, grant=0, req_ready=0, tx_valid=0, tx_data=0, timeout_err=0, counter=0 and last_winner=N_REQ-1, independent of clock.
REQ-030 Reset mid-frame SHALL abandon the frame with no further transfers; after release, arbitration restarts from requester 0.
REQ-031 Deassertion SHALL take effect at the first rising clock edge with reset_n=1.

Verification
REQ-032 Single frame: req_valid[1]=1, bytes 0x41,0x42 (last on 0x42), tx_ready=1 -> tx sequence 0xA1,0x41,0x42; grant=0b0010 for 3 cycles, then 0.
REQ-033 Contention: all four requesters hold 1-byte frames, tx_ready=1 -> headers 0xA0,0xA1,0xA2,0xA3 in that order, each followed by its byte, no gaps beyond one IDLE cycle per frame.
REQ-034 Frame lock: requester 2 mid-frame with requester 0 valid -> no 0xA0 header until requester 2 sends its last byte.
REQ-035 Timeout: TIMEOUT=8, requester 3 sends one non-last byte then drops valid -> timeout_err pulses once 8 cycles later, grant=0; requester 0 then wins next.
REQ-036 Backpressure: tx_ready=0 for 5 cycles during DATA -> tx_data stable, req_ready=0, no timeout, no byte loss or duplication.
REQ-037 Async reset: reset_n pulled low between clock edges mid-frame -> tx_valid and grant drop to 0 without a clock edge; first post-reset frame goes to requester 0.
